// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle control sequencer for the 16-bit RISC core.
// Walks each fetched instruction through DECODE/EXEC/MEM/WB and issues the
// ALU, register-file, data-memory and PC control strobes for every step.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (opcodes 1001-1110 trap to HALT
// with illegal=1 instead of executing as NOP).
module alu_ctrl_fsm #(
    parameter int         IW       = 16,
    parameter logic [3:0] HALT_OPC = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          zero,
    input  logic          mem_ready,
    output logic [1:0]    alu_op,
    output logic          alu_src_imm,
    output logic          reg_write,
    output logic          wb_sel_mem,
    output logic          mem_read,
    output logic          mem_write,
    output logic          pc_write,
    output logic [1:0]    pc_src,
    output logic          halted,
    output logic          illegal
);

    localparam logic [3:0] OPC_ADDI = 4'h4;
    localparam logic [3:0] OPC_LW   = 4'h5;
    localparam logic [3:0] OPC_SW   = 4'h6;
    localparam logic [3:0] OPC_BEQ  = 4'h7;
    localparam logic [3:0] OPC_J    = 4'h8;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t        state_q;
    logic [IW-1:0] ir_q;
    logic [3:0]    opc;

    assign opc = ir_q[IW-1 -: 4];

    // Operand/immediate fields are consumed by the datapath, not the sequencer.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[IW-5:0];

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // State and instruction register; reset wins over every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opc == HALT_OPC) begin
                        state_q <= S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    end else if (opc > OPC_J) begin
                        state_q   <= S_HALT;
                        illegal_q <= 1'b1;
`endif
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (opc <= OPC_ADDI)
                        state_q <= S_WB;
                    else if (opc == OPC_LW || opc == OPC_SW)
                        state_q <= S_MEM;
                    else
                        state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready)
                        state_q <= (opc == OPC_LW) ? S_WB : S_FETCH;
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Control strobes decoded from the registered state and opcode; beq and
    // sw completion additionally look at zero / mem_ready in their own cycle.
    always_comb begin
        instr_ready = 1'b0;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        wb_sel_mem  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        halted      = 1'b0;

        // ALU controls are set in EXEC and held through MEM and WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (opc)
                4'h0, 4'h1, 4'h2, 4'h3:     alu_op = opc[1:0];
                OPC_ADDI, OPC_LW, OPC_SW:   alu_src_imm = 1'b1;
                OPC_BEQ:                    alu_op = 2'b01;
                default:                    alu_op = 2'b00;
            endcase
        end

        case (state_q)
            S_FETCH: instr_ready = 1'b1;
            S_EXEC: begin
                case (opc)
                    4'h0, 4'h1, 4'h2, 4'h3, OPC_ADDI, OPC_LW, OPC_SW: pc_write = 1'b0;
                    OPC_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = zero ? 2'b01 : 2'b00;
                    end
                    OPC_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                    default: pc_write = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_read  = (opc == OPC_LW);
                mem_write = (opc == OPC_SW);
                pc_write  = (opc == OPC_SW) && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                wb_sel_mem = (opc == OPC_LW);
            end
            S_HALT:  halted = 1'b1;
            default: instr_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: table of instruction vectors with expected per-
// instruction results queued at issue and compared at retirement, plus
// hand-written reset-in-MEM, HALT and illegal/NOP sequences.
module tb_alu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        zero;
    logic        mem_ready;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        wb_sel_mem;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_fsm #(.IW(16), .HALT_OPC(4'hF)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
        .wb_sel_mem(wb_sel_mem), .mem_read(mem_read), .mem_write(mem_write),
        .pc_write(pc_write), .pc_src(pc_src), .halted(halted), .illegal(illegal)
    );

    typedef struct {
        logic [15:0] instr;
        logic        zero;
        int          waits;
        int          cyc;
        int          rw;
        int          pw;
        logic [1:0]  pcsrc;
        logic        wbsel;
        logic [1:0]  aluop;
        logic        imm;
        int          mrd;
        int          mwr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic logic [12:0] outs();
        return {instr_ready, alu_op, alu_src_imm, reg_write, wb_sel_mem,
                mem_read, mem_write, pc_write, pc_src, halted, illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] i, input logic z, input int w,
                                input int c, input int rw, input int pw,
                                input logic [1:0] ps, input logic wb,
                                input logic [1:0] ao, input logic im,
                                input int mr, input int mw);
        vec_t v;
        v.instr = i; v.zero = z; v.waits = w; v.cyc = c; v.rw = rw; v.pw = pw;
        v.pcsrc = ps; v.wbsel = wb; v.aluop = ao; v.imm = im; v.mrd = mr; v.mwr = mw;
        return v;
    endfunction

    // Issues one instruction from FETCH (called at negedge+1) and observes it
    // until instr_ready returns; mem_ready answers after v.waits MEM cycles and
    // is held high whenever no memory access is pending.
    task automatic run_vec(input vec_t v);
        vec_t a;
        vec_t e;
        int   mc;
        int   dirty;
        int   ill;
        bit   done;
        exp_q.push_back(v);
        a = v;
        a.cyc = 0; a.rw = 0; a.pw = 0; a.pcsrc = 2'b00; a.wbsel = 1'b0;
        a.aluop = 2'b00; a.imm = 1'b0; a.mrd = 0; a.mwr = 0;
        mc = 0; dirty = 0; ill = 0; done = 1'b0;
        zero = v.zero; instr = v.instr; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0; instr = 16'h0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                mem_ready = (mc == v.waits);
                mc++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (instr_ready) begin
                done = 1'b1;
            end else begin
                a.cyc++;
                if (a.cyc == 1 && (alu_op != 2'b00 || alu_src_imm)) dirty++;
                if (a.cyc == 2) begin a.aluop = alu_op; a.imm = alu_src_imm; end
                if (reg_write) begin a.rw++; a.wbsel = wb_sel_mem; end
                if (pc_write) begin a.pw++; a.pcsrc = pc_src; end
                if (mem_read) a.mrd++;
                if (mem_write) a.mwr++;
                if (illegal || halted) ill++;
            end
        end
        mem_ready = 1'b0;
        e = exp_q.pop_front();
        chk($sformatf("retire_%h", e.instr), done, 1);
        chk($sformatf("cycles_%h", e.instr), a.cyc, e.cyc);
        chk($sformatf("reg_write_cnt_%h", e.instr), a.rw, e.rw);
        chk($sformatf("pc_write_cnt_%h", e.instr), a.pw, e.pw);
        chk($sformatf("pc_src_%h", e.instr), a.pcsrc, e.pcsrc);
        chk($sformatf("wb_sel_mem_%h", e.instr), a.wbsel, e.wbsel);
        chk($sformatf("exec_alu_op_%h", e.instr), a.aluop, e.aluop);
        chk($sformatf("exec_imm_%h", e.instr), a.imm, e.imm);
        chk($sformatf("mem_read_cyc_%h", e.instr), a.mrd, e.mrd);
        chk($sformatf("mem_write_cyc_%h", e.instr), a.mwr, e.mwr);
        chk($sformatf("decode_alu_idle_%h", e.instr), dirty, 0);
        chk($sformatf("no_halt_%h", e.instr), ill, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 chk("reset_outputs_during_rst", outs(), 13'h1000);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = 16'h0; instr_valid = 1'b0; zero = 1'b0; mem_ready = 1'b0;

        //        instr    z  W  cyc rw pw pcsrc wb  aluop imm mrd mwr
        vecs.push_back(mk(16'h0123, 0, 0, 3, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(16'h1456, 0, 0, 3, 1, 1, 2'b00, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk(16'h2001, 1, 0, 3, 1, 1, 2'b00, 0, 2'b10, 0, 0, 0));
        vecs.push_back(mk(16'h3abc, 0, 0, 3, 1, 1, 2'b00, 0, 2'b11, 0, 0, 0));
        vecs.push_back(mk(16'h4ffe, 0, 0, 3, 1, 1, 2'b00, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(16'h5003, 0, 3, 7, 1, 1, 2'b00, 1, 2'b00, 1, 4, 0));
        vecs.push_back(mk(16'h5000, 0, 0, 4, 1, 1, 2'b00, 1, 2'b00, 1, 1, 0));
        vecs.push_back(mk(16'h6002, 0, 2, 5, 0, 1, 2'b00, 0, 2'b00, 1, 0, 3));
        vecs.push_back(mk(16'h7001, 1, 0, 2, 0, 1, 2'b01, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk(16'h7001, 0, 0, 2, 0, 1, 2'b00, 0, 2'b01, 0, 0, 0));
        vecs.push_back(mk(16'h8123, 1, 0, 2, 0, 1, 2'b10, 0, 2'b00, 0, 0, 0));
`ifndef CTRL_ILLEGAL_TRAP_EN
        vecs.push_back(mk(16'h9000, 0, 0, 2, 0, 1, 2'b00, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(16'hE000, 1, 0, 2, 0, 1, 2'b00, 0, 2'b00, 0, 0, 0));
`endif

        do_reset();
        // instr_valid without prior handshake: FETCH must hold, ready stays 1
        @(negedge clk);
        #1 chk("idle_fetch_outputs", outs(), 13'h1000);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset during MEM of sw while memory is stalled
        begin
            bit seen;
            seen = 1'b0;
            instr = 16'h6000; instr_valid = 1'b1; mem_ready = 1'b0;
            @(posedge clk);
            #1 instr_valid = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                #1 if (mem_write) seen = 1'b1;
            end
            chk("sw_reached_mem", seen, 1);
            rst = 1'b1;
            #1 chk("sw_stall_no_pc_write", pc_write, 0);
            @(negedge clk);
            #1;
            chk("rst_mem_write_dropped", mem_write, 0);
            chk("rst_mem_instr_ready", instr_ready, 1);
            chk("rst_mem_no_pc_write", pc_write, 0);
            rst = 1'b0;
        end

        // HALT opcode: stays halted through instr_valid pulses until reset
        instr = 16'hF000; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        #1 chk("halt_decode_not_halted", halted, 0);
        @(negedge clk);
        #1 chk("halt_outputs", outs(), 13'h0002);
        instr = 16'h0123; mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr_valid = (k % 2 == 0);
            @(negedge clk);
            #1 chk($sformatf("halt_hold_%0d", k), outs(), 13'h0002);
        end
        instr_valid = 1'b0; mem_ready = 1'b0;
        do_reset();
        chk("halt_cleared", halted, 0);

`ifdef CTRL_ILLEGAL_TRAP_EN
        // Reserved opcode traps straight from DECODE
        instr = 16'h9000; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        #1 chk("illegal_decode_clean", outs(), 13'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk($sformatf("illegal_trap_%0d", k), outs(), 13'h0003);
        end
        do_reset();
        chk("illegal_cleared", illegal, 0);
`endif

        // One more instruction after reset to confirm normal operation resumes
        run_vec(mk(16'h0123, 0, 0, 3, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
